// File: rtl/axi_riscv_amo_engine_if.sv
// Request/response port and single-beat AXI4 master subset of the AMO engine.
// The master modport is the engine's view; slave is the requester/memory side.
interface axi_riscv_amo_engine_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
);
  logic                        req_valid_i;
  logic                        req_ready_o;
  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i;
  logic [3:0]                  req_op_i;
  logic [AXI_DATA_WIDTH-1:0]   req_data_i;
  logic [AXI_ID_WIDTH-1:0]     req_id_i;

  logic                        resp_valid_o;
  logic                        resp_ready_i;
  logic [AXI_DATA_WIDTH-1:0]   resp_data_o;
  logic                        resp_err_o;
  logic [AXI_ID_WIDTH-1:0]     resp_id_o;

  logic                        mst_ar_valid_o;
  logic                        mst_ar_ready_i;
  logic [AXI_ADDR_WIDTH-1:0]   mst_ar_addr_o;
  logic [AXI_ID_WIDTH-1:0]     mst_ar_id_o;

  logic                        mst_r_valid_i;
  logic                        mst_r_ready_o;
  logic [AXI_DATA_WIDTH-1:0]   mst_r_data_i;
  logic [1:0]                  mst_r_resp_i;

  logic                        mst_aw_valid_o;
  logic                        mst_aw_ready_i;
  logic [AXI_ADDR_WIDTH-1:0]   mst_aw_addr_o;
  logic [AXI_ID_WIDTH-1:0]     mst_aw_id_o;

  logic                        mst_w_valid_o;
  logic                        mst_w_ready_i;
  logic [AXI_DATA_WIDTH-1:0]   mst_w_data_o;
  logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb_o;
  logic                        mst_w_last_o;

  logic                        mst_b_valid_i;
  logic                        mst_b_ready_o;
  logic [1:0]                  mst_b_resp_i;

  modport master (
    input  req_valid_i, req_addr_i, req_op_i, req_data_i, req_id_i,
    output req_ready_o,
    output resp_valid_o, resp_data_o, resp_err_o, resp_id_o,
    input  resp_ready_i,
    output mst_ar_valid_o, mst_ar_addr_o, mst_ar_id_o,
    input  mst_ar_ready_i,
    input  mst_r_valid_i, mst_r_data_i, mst_r_resp_i,
    output mst_r_ready_o,
    output mst_aw_valid_o, mst_aw_addr_o, mst_aw_id_o,
    input  mst_aw_ready_i,
    output mst_w_valid_o, mst_w_data_o, mst_w_strb_o, mst_w_last_o,
    input  mst_w_ready_i,
    input  mst_b_valid_i, mst_b_resp_i,
    output mst_b_ready_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_op_i, req_data_i, req_id_i,
    input  req_ready_o,
    input  resp_valid_o, resp_data_o, resp_err_o, resp_id_o,
    output resp_ready_i,
    input  mst_ar_valid_o, mst_ar_addr_o, mst_ar_id_o,
    output mst_ar_ready_i,
    output mst_r_valid_i, mst_r_data_i, mst_r_resp_i,
    input  mst_r_ready_o,
    input  mst_aw_valid_o, mst_aw_addr_o, mst_aw_id_o,
    output mst_aw_ready_i,
    input  mst_w_valid_o, mst_w_data_o, mst_w_strb_o, mst_w_last_o,
    output mst_w_ready_i,
    output mst_b_valid_i, mst_b_resp_i,
    input  mst_b_ready_o
  );
endinterface

// File: rtl/axi_riscv_amo_engine.sv
// Single-outstanding AMO engine: read-modify-write over a single-beat AXI4 master.
// All outputs are registered from the next state so zero-wait traffic advances one phase per cycle.
module axi_riscv_amo_engine #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  axi_riscv_amo_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                op_q;
  logic [AXI_DATA_WIDTH-1:0] opd_q, old_q, new_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic req_ready_q, ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q, resp_valid_q, resp_err_q;
  logic req_ready_d, ar_valid_d, r_ready_d, aw_valid_d, w_valid_d, b_ready_d, resp_valid_d, resp_err_d;
  logic [AXI_DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs, resp_hs;
  logic unused_resp_lsb;

  function automatic logic op_legal(input logic [3:0] op);
    return op < 4'd9;
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] alu(input logic [3:0] op,
                                                    input logic [AXI_DATA_WIDTH-1:0] old,
                                                    input logic [AXI_DATA_WIDTH-1:0] opd);
    case (op)
      4'd0:    return opd;
      4'd1:    return old + opd;
      4'd2:    return old & opd;
      4'd3:    return old | opd;
      4'd4:    return old ^ opd;
      4'd5:    return ($signed(opd) > $signed(old)) ? opd : old;
      4'd6:    return ($signed(opd) < $signed(old)) ? opd : old;
      4'd7:    return (opd > old) ? opd : old;
      4'd8:    return (opd < old) ? opd : old;
      default: return old;
    endcase
  endfunction

  assign req_hs  = bus.req_valid_i & req_ready_q;
  assign ar_hs   = ar_valid_q & bus.mst_ar_ready_i;
  assign r_hs    = r_ready_q & bus.mst_r_valid_i;
  assign aw_hs   = aw_valid_q & bus.mst_aw_ready_i;
  assign w_hs    = w_valid_q & bus.mst_w_ready_i;
  assign b_hs    = b_ready_q & bus.mst_b_valid_i;
  assign resp_hs = resp_valid_q & bus.resp_ready_i;

  assign unused_resp_lsb = bus.mst_r_resp_i[0] ^ bus.mst_b_resp_i[0];

  // Next state. An illegal op passes through AR for one cycle without raising ar_valid,
  // which gives the two-cycle error response with no bus traffic.
  always_comb begin
    state_d   = state_q;
    aw_done_d = (state_q == WR) && (aw_done_q || aw_hs);
    w_done_d  = (state_q == WR) && (w_done_q || w_hs);
    case (state_q)
      IDLE: if (req_hs) state_d = AR;
      AR: begin
        if (!op_legal(op_q)) state_d = RESP;
        else if (ar_hs)      state_d = R;
      end
      R:    if (r_hs) state_d = bus.mst_r_resp_i[1] ? RESP : WR;
      WR:   if (aw_done_d && w_done_d) state_d = B;
      B:    if (b_hs) state_d = RESP;
      RESP: if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = (state_d == IDLE);
    ar_valid_d   = (state_d == AR) && ((state_q == AR) || op_legal(bus.req_op_i));
    r_ready_d    = (state_d == R);
    aw_valid_d   = (state_d == WR) && !aw_done_d;
    w_valid_d    = (state_d == WR) && !w_done_d;
    b_ready_d    = (state_d == B);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    if (state_d == RESP && state_q != RESP) begin
      if (state_q == B) begin
        resp_err_d  = bus.mst_b_resp_i[1];
        resp_data_d = old_q;
      end else begin
        resp_err_d  = 1'b1;
        resp_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= '0;
      opd_q        <= '0;
      old_q        <= '0;
      new_q        <= '0;
      addr_q       <= '0;
      id_q         <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      b_ready_q    <= b_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      if (req_hs) begin
        op_q   <= bus.req_op_i;
        opd_q  <= bus.req_data_i;
        addr_q <= bus.req_addr_i;
        id_q   <= bus.req_id_i;
      end
      if (r_hs) begin
        old_q <= bus.mst_r_data_i;
        new_q <= alu(op_q, bus.mst_r_data_i, opd_q);
      end
    end
  end

  assign bus.req_ready_o    = req_ready_q;
  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.resp_data_o    = resp_data_q;
  assign bus.resp_err_o     = resp_err_q;
  assign bus.resp_id_o      = id_q;
  assign bus.mst_ar_valid_o = ar_valid_q;
  assign bus.mst_ar_addr_o  = addr_q;
  assign bus.mst_ar_id_o    = id_q;
  assign bus.mst_r_ready_o  = r_ready_q;
  assign bus.mst_aw_valid_o = aw_valid_q;
  assign bus.mst_aw_addr_o  = addr_q;
  assign bus.mst_aw_id_o    = id_q;
  assign bus.mst_w_valid_o  = w_valid_q;
  assign bus.mst_w_data_o   = new_q;
  assign bus.mst_w_strb_o   = '1;
  assign bus.mst_w_last_o   = 1'b1;
  assign bus.mst_b_ready_o  = b_ready_q;
endmodule

// File: tb/tb_axi_riscv_amo_engine.sv
// Directed bench for axi_riscv_amo_engine: memory-backed AXI slave model plus response scoreboard.
module tb_axi_riscv_amo_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_riscv_amo_engine_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) bus ();

  axi_riscv_amo_engine #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  // Slave model state and knobs
  logic [63:0] mem [logic [63:0]];
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [63:0] last_ar_addr = '0, last_aw_addr = '0, last_w_data = '0;
  logic [7:0]  last_w_strb = '0;
  logic        last_w_last = 1'b0;
  int          aw_delay = 0;
  logic        r_err = 1'b0, b_err = 1'b0, b_stall = 1'b0;

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  initial begin : slave
    logic        pend_r, aw_seen, w_seen, b_pend;
    logic [63:0] raddr, waddr, wdata;
    int          aw_wait;
    pend_r = 0; aw_seen = 0; w_seen = 0; b_pend = 0; aw_wait = 0;
    raddr = '0; waddr = '0; wdata = '0;
    bus.mst_ar_ready_i = 0; bus.mst_aw_ready_i = 0; bus.mst_w_ready_i = 0;
    bus.mst_r_valid_i = 0; bus.mst_r_data_i = '0; bus.mst_r_resp_i = '0;
    bus.mst_b_valid_i = 0; bus.mst_b_resp_i = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend_r = 0; aw_seen = 0; w_seen = 0; b_pend = 0; aw_wait = 0;
      end else begin
        if (bus.mst_r_valid_i && bus.mst_r_ready_o) pend_r = 0;
        if (bus.mst_ar_valid_o && bus.mst_ar_ready_i) begin
          ar_cnt++; last_ar_addr = bus.mst_ar_addr_o; raddr = bus.mst_ar_addr_o; pend_r = 1;
        end
        if (bus.mst_aw_valid_o && bus.mst_aw_ready_i) begin
          aw_cnt++; last_aw_addr = bus.mst_aw_addr_o; waddr = bus.mst_aw_addr_o; aw_seen = 1; aw_wait = 0;
        end else if (bus.mst_aw_valid_o) aw_wait++;
        if (bus.mst_w_valid_o && bus.mst_w_ready_i) begin
          w_cnt++; last_w_data = bus.mst_w_data_o; last_w_strb = bus.mst_w_strb_o;
          last_w_last = bus.mst_w_last_o; wdata = bus.mst_w_data_o; w_seen = 1;
        end
        if (bus.mst_b_valid_i && bus.mst_b_ready_o) b_pend = 0;
      end
      @(negedge clk);
      if (aw_seen && w_seen && !rst) begin
        mem[waddr] = wdata; b_pend = 1; aw_seen = 0; w_seen = 0;
      end
      bus.mst_ar_ready_i = 1;
      bus.mst_w_ready_i  = 1;
      bus.mst_aw_ready_i = bus.mst_aw_valid_o && (aw_wait >= aw_delay);
      bus.mst_r_valid_i  = pend_r;
      bus.mst_r_data_i   = r_err ? 64'hDEAD_BEEF_0BAD_F00D : rd(raddr);
      bus.mst_r_resp_i   = r_err ? 2'b10 : 2'b00;
      bus.mst_b_valid_i  = b_pend && !b_stall;
      bus.mst_b_resp_i   = b_err ? 2'b10 : 2'b00;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] addr, input logic [3:0] op, input logic [63:0] opd,
                      input logic [3:0] id, output int k);
    int n;
    @(negedge clk);
    bus.req_valid_i = 1; bus.req_addr_i = addr; bus.req_op_i = op;
    bus.req_data_i = opd; bus.req_id_i = id;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin @(negedge clk); n++; end
    chk("req_accept", {63'b0, bus.req_ready_o}, 64'd1);
    k = cyc;
    @(negedge clk);
    bus.req_valid_i = 0;
  endtask

  task automatic wait_resp(output int t);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.resp_valid_o && n < 60) begin @(negedge clk); n++; end
    chk("resp_seen", {63'b0, bus.resp_valid_o}, 64'd1);
    t = cyc;
    chk("sb_nonempty", {63'b0, sbq.size() != 0}, 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("resp_data", bus.resp_data_o, e.data);
      chk("resp_err", {63'b0, bus.resp_err_o}, {63'b0, e.err});
      chk("resp_id", {60'b0, bus.resp_id_o}, {60'b0, e.id});
    end
    @(negedge clk);
  endtask

  function automatic logic [5:0] valids();
    return {bus.mst_ar_valid_o, bus.mst_r_ready_o, bus.mst_aw_valid_o,
            bus.mst_w_valid_o, bus.mst_b_ready_o, bus.resp_valid_o};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    int k, t, a0, w0, r0;
    logic [63:0] av, bv;
    logic [3:0]  ops [6];
    logic [63:0] expw [6];
    bus.req_valid_i = 0; bus.req_addr_i = '0; bus.req_op_i = '0;
    bus.req_data_i = '0; bus.req_id_i = '0; bus.resp_ready_i = 1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'b0, bus.req_ready_o}, 64'd1);
    chk("rst_valids", {58'b0, valids()}, 64'd0);
    chk("rst_resp_data", bus.resp_data_o, 64'd0);
    chk("rst_ar_addr", bus.mst_ar_addr_o, 64'd0);
    chk("rst_w_data", bus.mst_w_data_o, 64'd0);
    rst = 0;

    // ADD, zero-wait slave
    mem[64'h100] = 64'd5;
    sbq.push_back('{id: 4'd1, data: 64'd5, err: 1'b0});
    send(64'h100, 4'd1, 64'd3, 4'd1, k);
    wait_resp(t);
    chk("add_latency", t - k, 64'd5);
    chk("add_ar_addr", last_ar_addr, 64'h100);
    chk("add_aw_addr", last_aw_addr, 64'h100);
    chk("add_w_data", last_w_data, 64'd8);
    chk("add_w_strb", {56'b0, last_w_strb}, 64'hFF);
    chk("add_w_last", {63'b0, last_w_last}, 64'd1);
    chk("add_mem", rd(64'h100), 64'd8);

    // MIN vs MINU on all-ones
    mem[64'h200] = '1;
    sbq.push_back('{id: 4'd2, data: 64'hFFFF_FFFF_FFFF_FFFF, err: 1'b0});
    send(64'h200, 4'd6, 64'd1, 4'd2, k);
    wait_resp(t);
    chk("min_w_data", last_w_data, 64'hFFFF_FFFF_FFFF_FFFF);
    mem[64'h208] = '1;
    sbq.push_back('{id: 4'd3, data: 64'hFFFF_FFFF_FFFF_FFFF, err: 1'b0});
    send(64'h208, 4'd8, 64'd1, 4'd3, k);
    wait_resp(t);
    chk("minu_w_data", last_w_data, 64'd1);

    // SLVERR on read: no write
    r_err = 1; a0 = aw_cnt; w0 = w_cnt;
    sbq.push_back('{id: 4'd9, data: 64'd0, err: 1'b1});
    send(64'h300, 4'd0, 64'h55, 4'd9, k);
    wait_resp(t);
    chk("slverr_no_aw", aw_cnt - a0, 64'd0);
    chk("slverr_no_w", w_cnt - w0, 64'd0);
    r_err = 0;

    // AW ready delayed 3 cycles, W ready immediately
    aw_delay = 3; mem[64'h400] = 64'd10;
    sbq.push_back('{id: 4'd4, data: 64'd10, err: 1'b0});
    send(64'h400, 4'd1, 64'd1, 4'd4, k);
    repeat (2) @(negedge clk);
    chk("awd_aw_valid_start", {63'b0, bus.mst_aw_valid_o}, 64'd1);
    chk("awd_w_valid_start", {63'b0, bus.mst_w_valid_o}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("awd_aw_held", {63'b0, bus.mst_aw_valid_o}, 64'd1);
      chk("awd_w_dropped", {63'b0, bus.mst_w_valid_o}, 64'd0);
      chk("awd_no_b", {63'b0, bus.mst_b_ready_o}, 64'd0);
    end
    @(negedge clk);
    chk("awd_aw_done", {63'b0, bus.mst_aw_valid_o}, 64'd0);
    chk("awd_b_ready", {63'b0, bus.mst_b_ready_o}, 64'd1);
    wait_resp(t);
    chk("awd_latency", t - k, 64'd8);
    chk("awd_mem", rd(64'h400), 64'd11);
    aw_delay = 0;

    // B error propagates with old data
    b_err = 1; mem[64'h480] = 64'd77;
    sbq.push_back('{id: 4'd10, data: 64'd77, err: 1'b1});
    send(64'h480, 4'd3, 64'h100, 4'd10, k);
    wait_resp(t);
    b_err = 0;

    // Illegal op: no bus activity, error after two cycles
    a0 = aw_cnt; w0 = w_cnt; r0 = ar_cnt;
    sbq.push_back('{id: 4'd5, data: 64'd0, err: 1'b1});
    send(64'h500, 4'd12, 64'd7, 4'd5, k);
    wait_resp(t);
    chk("illegal_latency", t - k, 64'd2);
    chk("illegal_no_ar", ar_cnt - r0, 64'd0);
    chk("illegal_no_aw", aw_cnt - a0, 64'd0);
    chk("illegal_no_w", w_cnt - w0, 64'd0);

    // Remaining ALU ops with signed/unsigned-sensitive operands
    av = 64'hF0F0_0000_0000_1234;
    bv = 64'h0FF0_0000_0000_4321;
    ops[0] = 4'd0; expw[0] = 64'h0FF0_0000_0000_4321;
    ops[1] = 4'd2; expw[1] = 64'h00F0_0000_0000_0220;
    ops[2] = 4'd3; expw[2] = 64'hFFF0_0000_0000_5335;
    ops[3] = 4'd4; expw[3] = 64'hFF00_0000_0000_5115;
    ops[4] = 4'd5; expw[4] = 64'h0FF0_0000_0000_4321;
    ops[5] = 4'd7; expw[5] = 64'hF0F0_0000_0000_1234;
    for (int i = 0; i < 6; i++) begin
      mem[64'h800 + 64'(i * 8)] = av;
      sbq.push_back('{id: 4'(i), data: av, err: 1'b0});
      send(64'h800 + 64'(i * 8), ops[i], bv, 4'(i), k);
      wait_resp(t);
      chk($sformatf("alu_op%0d_w_data", ops[i]), last_w_data, expw[i]);
    end

    // Reset while waiting in B, then a clean ADD
    b_stall = 1;
    send(64'h600, 4'd1, 64'd1, 4'd6, k);
    for (int i = 0; i < 20 && !bus.mst_b_ready_o; i++) @(negedge clk);
    chk("in_b_state", {63'b0, bus.mst_b_ready_o}, 64'd1);
    rst = 1;
    @(negedge clk);
    chk("midrst_valids", {58'b0, valids()}, 64'd0);
    chk("midrst_req_ready", {63'b0, bus.req_ready_o}, 64'd1);
    rst = 0; b_stall = 0;
    mem[64'h700] = 64'd100;
    sbq.push_back('{id: 4'd7, data: 64'd100, err: 1'b0});
    send(64'h700, 4'd1, 64'd23, 4'd7, k);
    wait_resp(t);
    chk("post_rst_latency", t - k, 64'd5);
    chk("post_rst_w_data", last_w_data, 64'd123);
    chk("sb_drained", sbq.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
